// File: rtl/spi_slave_if.sv
// SPI slave front end: deserialises (ADDR_SIZE+2)-bit MOSI frames for the RAM stage and shifts RAM read bytes out on MISO.
// Optional macro SPI_FRAME_ERR_EN adds a sticky frame_err output flagging aborted frames.
module spi_slave_if #(
  parameter int ADDR_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 SS_n,
  input  logic                 MOSI,
  output logic                 MISO,
  output logic [ADDR_SIZE+1:0] rx_data,
  output logic                 rx_valid,
  input  logic [ADDR_SIZE-1:0] tx_data,
  input  logic                 tx_valid
`ifdef SPI_FRAME_ERR_EN
  ,
  output logic                 frame_err
`endif
);

  localparam int FRAME_W = ADDR_SIZE + 2;
  localparam int CNT_W   = $clog2(ADDR_SIZE + 2);

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA,
    WAIT_TX,
    SHIFT_OUT,
    DONE
  } state_t;

  state_t               state_q, state_d;
  logic [FRAME_W-2:0]   rx_sh_q, rx_sh_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [ADDR_SIZE-1:0] tx_sh_q, tx_sh_d;
  logic                 miso_q, miso_d;
  logic [FRAME_W-1:0]   rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 rd_addr_seen_q, rd_addr_seen_d;

  always_comb begin
    state_d        = state_q;
    rx_sh_d        = rx_sh_q;
    cnt_d          = cnt_q;
    tx_sh_d        = tx_sh_q;
    miso_d         = 1'b0;
    rx_data_d      = rx_data_q;
    rx_valid_d     = 1'b0;
    rd_addr_seen_d = rd_addr_seen_q;

    // SS_n high outside IDLE ends the frame; this also wins over a completing last bit.
    if (state_q != IDLE && SS_n) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!SS_n) begin
            state_d = CHK_CMD;
            cnt_d   = '0;
          end
        end
        CHK_CMD: begin
          rx_sh_d = {{(FRAME_W-2){1'b0}}, MOSI};
          cnt_d   = '0;
          if (!MOSI)               state_d = WRITE;
          else if (rd_addr_seen_q) state_d = READ_DATA;
          else                     state_d = READ_ADD;
        end
        WRITE, READ_ADD, READ_DATA: begin
          if (cnt_q == CNT_W'(ADDR_SIZE)) begin
            rx_data_d  = {rx_sh_q, MOSI};
            rx_valid_d = 1'b1;
            cnt_d      = '0;
            if (state_q == READ_ADD)  rd_addr_seen_d = 1'b1;
            if (state_q == READ_DATA) rd_addr_seen_d = 1'b0;
            state_d = (state_q == READ_DATA) ? WAIT_TX : DONE;
          end else begin
            rx_sh_d = {rx_sh_q[FRAME_W-3:0], MOSI};
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end
        WAIT_TX: begin
          if (tx_valid) begin
            tx_sh_d = tx_data;
            miso_d  = tx_data[ADDR_SIZE-1];
            cnt_d   = CNT_W'(1);
            state_d = SHIFT_OUT;
          end
        end
        SHIFT_OUT: begin
          // cnt_q counts bits already on the wire; once all are out, return MISO low.
          if (cnt_q == CNT_W'(ADDR_SIZE)) begin
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            tx_sh_d = tx_sh_q << 1;
            miso_d  = tx_sh_q[ADDR_SIZE-2];
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end
        DONE: begin
          state_d = DONE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      rx_sh_q        <= '0;
      cnt_q          <= '0;
      tx_sh_q        <= '0;
      miso_q         <= 1'b0;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
      rd_addr_seen_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      rx_sh_q        <= rx_sh_d;
      cnt_q          <= cnt_d;
      tx_sh_q        <= tx_sh_d;
      miso_q         <= miso_d;
      rx_data_q      <= rx_data_d;
      rx_valid_q     <= rx_valid_d;
      rd_addr_seen_q <= rd_addr_seen_d;
    end
  end

  assign MISO     = miso_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;

`ifdef SPI_FRAME_ERR_EN
  logic frame_err_q, frame_err_d;
  logic abort;

  always_comb begin
    abort       = SS_n && (state_q != IDLE) && (state_q != DONE);
    frame_err_d = frame_err_q;
    if (abort)           frame_err_d = 1'b1;
    else if (rx_valid_d) frame_err_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) frame_err_q <= 1'b0;
    else        frame_err_q <= frame_err_d;
  end

  assign frame_err = frame_err_q;
`endif

endmodule

// File: tb/tb_spi_slave_if.sv
// Directed testbench for spi_slave_if: frame reception, read-out serialisation, aborts and async reset.
module tb_spi_slave_if;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       SS_n;
  logic       MOSI;
  logic       MISO;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
`ifdef SPI_FRAME_ERR_EN
  logic       frame_err;
`endif

  int total = 0;
  int bad   = 0;
  int vcount = 0;
  int ones   = 0;

  spi_slave_if #(.ADDR_SIZE(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .SS_n     (SS_n),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid)
`ifdef SPI_FRAME_ERR_EN
    ,
    .frame_err(frame_err)
`endif
  );

  always #5 clk = ~clk;

  // rx_valid pulses and MISO-high cycles, sampled mid-cycle
  always @(posedge clk) begin
    #2;
    if (rx_valid === 1'b1) vcount++;
    if (MISO === 1'b1) ones++;
  end

  task automatic do_frame(input logic [9:0] f, output logic v, output logic [9:0] d);
    @(negedge clk);
    SS_n = 1'b0;
    MOSI = 1'b0;
    for (int i = 9; i >= 0; i--) begin
      @(negedge clk);
      MOSI = f[i];
    end
    @(negedge clk);
    v = rx_valid;
    d = rx_data;
  endtask

  task automatic ss_high();
    @(negedge clk);
    SS_n = 1'b1;
    MOSI = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; SS_n = 1'b1; MOSI = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
    @(negedge clk);
    @(negedge clk);
    total++; if (MISO !== 1'b0) begin bad++; $display("FAIL reset_miso got=%b exp=0", MISO); end
    total++; if (rx_data !== 10'h000) begin bad++; $display("FAIL reset_rx_data got=%h exp=000", rx_data); end
    total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL reset_rx_valid got=%b exp=0", rx_valid); end
    total++; if (dut.rd_addr_seen_q !== 1'b0) begin bad++; $display("FAIL reset_rd_addr_seen got=%b exp=0", dut.rd_addr_seen_q); end
`ifdef SPI_FRAME_ERR_EN
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_frame_err got=%b exp=0", frame_err); end
`endif
    rst_n = 1'b1;
  endtask

  task automatic test_write();
    logic v; logic [9:0] d; int c0, o0;
    c0 = vcount; o0 = ones;
    do_frame(10'h0A5, v, d);
    total++; if (v !== 1'b1) begin bad++; $display("FAIL wr1_valid got=%b exp=1", v); end
    total++; if (d !== 10'h0A5) begin bad++; $display("FAIL wr1_data got=%h exp=0a5", d); end
    @(negedge clk);
    total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL wr1_pulse_width got=%b exp=0", rx_valid); end
    ss_high();
    do_frame(10'h13C, v, d);
    total++; if (v !== 1'b1) begin bad++; $display("FAIL wr2_valid got=%b exp=1", v); end
    total++; if (d !== 10'h13C) begin bad++; $display("FAIL wr2_data got=%h exp=13c", d); end
    ss_high();
    total++; if (rx_data !== 10'h13C) begin bad++; $display("FAIL wr2_hold got=%h exp=13c", rx_data); end
    total++; if (vcount - c0 !== 2) begin bad++; $display("FAIL wr_pulse_count got=%0d exp=2", vcount - c0); end
    total++; if (ones - o0 !== 0) begin bad++; $display("FAIL wr_miso_quiet got=%0d exp=0", ones - o0); end
  endtask

  task automatic test_read();
    logic v; logic [9:0] d; logic [7:0] exp_b;
    exp_b = 8'hC3;
    do_frame(10'h205, v, d);
    total++; if (v !== 1'b1) begin bad++; $display("FAIL rdadd_valid got=%b exp=1", v); end
    total++; if (d !== 10'h205) begin bad++; $display("FAIL rdadd_data got=%h exp=205", d); end
    total++; if (dut.rd_addr_seen_q !== 1'b1) begin bad++; $display("FAIL rdadd_seen got=%b exp=1", dut.rd_addr_seen_q); end
    ss_high();
    do_frame(10'h300, v, d);
    total++; if (v !== 1'b1) begin bad++; $display("FAIL rddat_valid got=%b exp=1", v); end
    total++; if (d !== 10'h300) begin bad++; $display("FAIL rddat_data got=%h exp=300", d); end
    @(negedge clk);
    total++; if (MISO !== 1'b0) begin bad++; $display("FAIL rd_wait_miso got=%b exp=0", MISO); end
    tx_valid = 1'b1; tx_data = 8'hC3;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      tx_valid = 1'b0;
      total++; if (MISO !== exp_b[7-k]) begin bad++; $display("FAIL rd_miso_bit%0d got=%b exp=%b", 7-k, MISO, exp_b[7-k]); end
    end
    @(negedge clk);
    total++; if (MISO !== 1'b0) begin bad++; $display("FAIL rd_miso_tail got=%b exp=0", MISO); end
    total++; if (dut.rd_addr_seen_q !== 1'b0) begin bad++; $display("FAIL rddat_seen got=%b exp=0", dut.rd_addr_seen_q); end
    tx_data = 8'h00;
    ss_high();
  endtask

  task automatic test_abort();
    logic v; logic [9:0] d; logic [9:0] f; int c0;
    f = 10'h0A5; c0 = vcount;
    @(negedge clk);
    SS_n = 1'b0;
    for (int i = 9; i >= 5; i--) begin
      @(negedge clk);
      MOSI = f[i];
    end
    @(negedge clk);
    SS_n = 1'b1;
    @(negedge clk);
    total++; if (vcount - c0 !== 0) begin bad++; $display("FAIL abort_no_valid got=%0d exp=0", vcount - c0); end
    total++; if (MISO !== 1'b0) begin bad++; $display("FAIL abort_miso got=%b exp=0", MISO); end
`ifdef SPI_FRAME_ERR_EN
    total++; if (frame_err !== 1'b1) begin bad++; $display("FAIL abort_frame_err_set got=%b exp=1", frame_err); end
`endif
    do_frame(10'h0FF, v, d);
    total++; if (v !== 1'b1) begin bad++; $display("FAIL after_abort_valid got=%b exp=1", v); end
    total++; if (d !== 10'h0FF) begin bad++; $display("FAIL after_abort_data got=%h exp=0ff", d); end
`ifdef SPI_FRAME_ERR_EN
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL frame_err_clear got=%b exp=0", frame_err); end
`endif
    ss_high();
  endtask

  task automatic test_same_edge_abort();
    logic [9:0] f; int c0;
    f = 10'h155; c0 = vcount;
    @(negedge clk);
    SS_n = 1'b0;
    for (int i = 9; i >= 1; i--) begin
      @(negedge clk);
      MOSI = f[i];
    end
    @(negedge clk);
    SS_n = 1'b1;
    MOSI = f[0];
    @(negedge clk);
    @(negedge clk);
    total++; if (vcount - c0 !== 0) begin bad++; $display("FAIL last_bit_abort_valid got=%0d exp=0", vcount - c0); end
    total++; if (rx_data !== 10'h0FF) begin bad++; $display("FAIL last_bit_abort_hold got=%h exp=0ff", rx_data); end
  endtask

  task automatic test_read_no_addr();
    logic v; logic [9:0] d; int o0;
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    do_frame(10'h3AA, v, d);
    total++; if (v !== 1'b1) begin bad++; $display("FAIL noaddr_valid got=%b exp=1", v); end
    total++; if (d !== 10'h3AA) begin bad++; $display("FAIL noaddr_data got=%h exp=3aa", d); end
    total++; if (dut.rd_addr_seen_q !== 1'b1) begin bad++; $display("FAIL noaddr_seen got=%b exp=1", dut.rd_addr_seen_q); end
    o0 = ones;
    tx_valid = 1'b1; tx_data = 8'hFF;
    repeat (12) @(negedge clk);
    tx_valid = 1'b0;
    total++; if (ones - o0 !== 0) begin bad++; $display("FAIL noaddr_no_shift got=%0d exp=0", ones - o0); end
    ss_high();
    do_frame(10'h300, v, d);
    total++; if (v !== 1'b1) begin bad++; $display("FAIL noaddr_rddat_valid got=%b exp=1", v); end
    total++; if (dut.rd_addr_seen_q !== 1'b0) begin bad++; $display("FAIL noaddr_rddat_seen got=%b exp=0", dut.rd_addr_seen_q); end
  endtask

  task automatic test_async_reset();
    logic v; logic [9:0] d; logic [7:0] exp_b;
    exp_b = 8'hA5;
    @(negedge clk);
    tx_valid = 1'b1; tx_data = 8'hA5;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      tx_valid = 1'b0;
      total++; if (MISO !== exp_b[7-k]) begin bad++; $display("FAIL ar_miso_bit%0d got=%b exp=%b", 7-k, MISO, exp_b[7-k]); end
    end
    #2 rst_n = 1'b0;
    #1;
    total++; if (MISO !== 1'b0) begin bad++; $display("FAIL ar_miso got=%b exp=0", MISO); end
    total++; if (rx_data !== 10'h000) begin bad++; $display("FAIL ar_rx_data got=%h exp=000", rx_data); end
    total++; if (dut.rd_addr_seen_q !== 1'b0) begin bad++; $display("FAIL ar_seen got=%b exp=0", dut.rd_addr_seen_q); end
    @(negedge clk);
    rst_n = 1'b1; SS_n = 1'b1;
    ss_high();
    do_frame(10'h0A5, v, d);
    total++; if (d !== 10'h0A5 || v !== 1'b1) begin bad++; $display("FAIL ar_recover got=%h/%b exp=0a5/1", d, v); end
    ss_high();
  endtask

  task automatic test_ss_held_low();
    logic v; logic [9:0] d; int c0;
    c0 = vcount;
    do_frame(10'h055, v, d);
    total++; if (v !== 1'b1 || d !== 10'h055) begin bad++; $display("FAIL held_first got=%h/%b exp=055/1", d, v); end
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      MOSI = ~MOSI;
    end
    @(negedge clk);
    total++; if (vcount - c0 !== 1) begin bad++; $display("FAIL held_no_second got=%0d exp=1", vcount - c0); end
    ss_high();
    do_frame(10'h066, v, d);
    total++; if (v !== 1'b1 || d !== 10'h066) begin bad++; $display("FAIL held_next got=%h/%b exp=066/1", d, v); end
    ss_high();
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_abort();
    test_same_edge_abort();
    test_read_no_addr();
    test_async_reset();
    test_ss_held_low();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
